// File: rtl/fesub.sv
// Word-serial subtractor over GF(2^255-19): out = (a_in - b_in) mod p.
// Raw and +p-corrected differences are built in parallel, LSW first.
module fesub #(
  parameter int W    = 17,
  parameter int N    = 15,
  parameter int C    = 19,
  parameter int LOGN = 4
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  output logic           busy,
  output logic           done,
  output logic [N*W-1:0] out
);

  localparam int L = N * W;
  localparam logic [LOGN-1:0] IDLE = LOGN'(N);
  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);
  // p = 2^L - C: word 0 is 2^W - C, every other word is all ones
  localparam logic [W-1:0] PW0 = W'((1 << W) - C);

  logic [LOGN-1:0] i_q, i_d;
  logic [L-1:0]    a_q, a_d;
  logic [L-1:0]    b_q, b_d;
  logic [L-1:0]    raw_q, raw_d;
  logic [L-1:0]    cor_q, cor_d;
  logic            borrow_q, borrow_d;
  logic            carry_q, carry_d;
  logic            sel_q, sel_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            run;
  logic [W-1:0]    pw;
  logic [W:0]      d;
  logic [W:0]      q;

  assign run = (i_q != IDLE);
  assign pw  = (i_q == '0) ? PW0 : '1;

  assign d = {1'b0, a_q[W-1:0]}
           - {1'b0, b_q[W-1:0]}
           - {{W{1'b0}}, borrow_q};
  assign q = {1'b0, d[W-1:0]}
           + {1'b0, pw}
           + {{W{1'b0}}, carry_q};

  always_comb begin
    i_d      = i_q;
    a_d      = a_q;
    b_d      = b_q;
    raw_d    = raw_q;
    cor_d    = cor_q;
    borrow_d = borrow_q;
    carry_d  = carry_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (start) begin
      i_d      = '0;
      a_d      = a_in;
      b_d      = b_in;
      borrow_d = 1'b0;
      carry_d  = 1'b0;
      busy_d   = 1'b1;
    end else if (run) begin
      i_d      = i_q + LOGN'(1);
      a_d      = a_q >> W;
      b_d      = b_q >> W;
      raw_d    = {d[W-1:0], raw_q[L-1:W]};
      cor_d    = {q[W-1:0], cor_q[L-1:W]};
      borrow_d = d[W];
      carry_d  = q[W];
      if (i_q == LAST) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        sel_d  = d[W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      i_q      <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      raw_q    <= '0;
      cor_q    <= '0;
      borrow_q <= 1'b0;
      carry_q  <= 1'b0;
      sel_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      i_q      <= i_d;
      a_q      <= a_d;
      b_q      <= b_d;
      raw_q    <= raw_d;
      cor_q    <= cor_d;
      borrow_q <= borrow_d;
      carry_q  <= carry_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = sel_q ? cor_q : raw_q;

endmodule

// File: doc/fesub.md
Name: fesub

Overview:
- Word-serial modular subtractor over GF(2^255-19). Computes out = (a_in - b_in) mod p.
- Counterpart to the field adder in the arithmetic datapath. Same W=17 / N=15 limb schedule, same start/done handshake, so the sequencer can drive either unit interchangeably.
- Computes the raw difference a-b and the corrected value a-b+p in parallel, one 17-bit word per cycle. Selects the corrected value when the raw subtraction borrows.

Parameters:
- W, 17, word (limb) width in bits
- N, 15, number of words per field element (N*W = 255)
- C, 19, pseudo-Mersenne coefficient
- P, 2^255-19, field modulus, derived from N, W and C
- LOGN, 4, width of the word counter

Ports:
- clock  input  1  single system clock, rising edge
- reset_n  input  1  synchronous, active-low reset
- start  input  1  one-cycle request; a_in and b_in are sampled on the same edge
- a_in  input  255  minuend, canonical (< P)
- b_in  input  255  subtrahend, canonical (< P)
- busy  output  1  high while words are being processed
- done  output  1  one-cycle pulse; out is valid from this cycle on
- out  output  255  result, canonical, held until the next start

Behaviour:
- Reset: the clock edge with reset_n=0 sets
  - done=0, busy=0, out=0
  - counter i=N (idle)
  - borrow=0, carryP=0, selection flag=0
  - internal operand copies and shift registers cleared
- Reset wins over start on the same edge. Reset mid-operation aborts the operation: no done pulse follows.
- States, encoded by counter i:
  - IDLE: i==N
  - RUN: i in 0..N-1
- Start (reset_n=1, start=1) on edge E0:
  - latch a_in and b_in; i<=0; borrow<=0; carryP<=0; busy<=1; done<=0
  - start is accepted in any state. Start during RUN discards the current operation and restarts from word 0.
- RUN, edge E(k+1), processes word k = i:
  - d = a[k] - b[k] - borrow, W+1 bits; new borrow = d[W]
  - q = d[W-1:0] + P[k] + carryP, W+1 bits; new carryP = q[W]
  - d[W-1:0] and q[W-1:0] are shifted into the raw and corrected result registers, LSW first
  - i<=i+1
- Final word (k==N-1), edge E15:
  - busy<=0; done<=1
  - sel<=final borrow
  - out = sel ? corrected : raw
- E16: done<=0, unless a start arrived on E15 (start on E15 restarts normally; done still drops on E16).
- Latency: done is high during the cycle after edge E15, i.e. 15 cycles after the start edge. Throughput is one operation per 16 cycles. Back-to-back operation is allowed with start asserted in the done cycle.
- The final carryP is discarded, since a-b+p is always < 2^255 when a borrow occurred.
- out is stable from done until the first RUN edge of the next operation.
- start ignored? No: start while IDLE with done=0 is always accepted.
- Non-canonical inputs are out of contract. out is congruent to a-b mod p only if the result is < 2^255. No reduction beyond one correction is performed.

Test Plan:
- Reset, then a=5, b=3, start → done exactly 15 cycles later, one cycle wide; out=2; busy high for 15 cycles.
- a=3, b=5 → out=P-2 = 2^255-21.
- a=0, b=P-1 → out=1. Then a=P-1, b=0 → out=P-1. Then a=b=0x1234_5678 → out=0.
- Random canonical pairs (≥1000), with starts issued back-to-back in the done cycle → out matches the (a-b) mod P reference model every time; no gaps, no missed done pulses.
- reset_n=0 for one cycle, 7 cycles after start → no done pulse, out=0, busy=0; a following start with a=10, b=4 yields out=6 after 15 cycles.
- start with a=9, b=1, then a second start 5 cycles later with a=1, b=9 → single done pulse 15 cycles after the second start; out=P-8.
